// File: rtl/lc3_int_ctrl_pkg.sv
// lc3_int_ctrl_pkg -- shared definitions for the LC3 interrupt/exception
// controller: FSM state encoding, VectorMUX select codes and the fixed
// exception vector numbers.
package lc3_int_ctrl_pkg;

  localparam int N_DEV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_READY = 2'b10,
    ST_ACK   = 2'b11
  } state_e;

  // VectorMUX select: which source the vector unit loads from.
  // VM_INT also serves as the "serviced event is an interrupt" marker.
  localparam logic [1:0] VM_INT   = 2'b00;
  localparam logic [1:0] VM_PRIV  = 2'b01;
  localparam logic [1:0] VM_ILLOP = 2'b10;
  localparam logic [1:0] VM_ACV   = 2'b11;

  // Exception vector numbers selected through the vector table.
  localparam logic [7:0] EXC_VEC_PRIV  = 8'h00;
  localparam logic [7:0] EXC_VEC_ILLOP = 8'h01;
  localparam logic [7:0] EXC_VEC_ACV   = 8'h02;

endpackage

// File: rtl/lc3_int_ctrl_prio.sv
// lc3_int_prio -- combinational 4-way interrupt priority resolver.
// Ports:
//   irq_req  [3:0]  level requests, device i on bit i
//   irq_pl   [11:0] 3-bit priority of device i on [3i+2:3i]
//   psr_pl   [2:0]  current processor priority level
//   any_elig        some device has irq_req=1 and pl > psr_pl
//   win_idx  [1:0]  eligible device with the highest pl (lowest index on tie)
//   win_pl   [2:0]  priority of that device
module lc3_int_prio
  import lc3_int_ctrl_pkg::*;
(
  input  logic [N_DEV-1:0]   irq_req,
  input  logic [3*N_DEV-1:0] irq_pl,
  input  logic [2:0]         psr_pl,
  output logic               any_elig,
  output logic [1:0]         win_idx,
  output logic [2:0]         win_pl
);

  always_comb begin
    any_elig = 1'b0;
    win_idx  = 2'd0;
    win_pl   = 3'd0;
    // Ascending scan with a strict ">" on replacement keeps the lowest index
    // among devices that share the highest priority.
    for (int i = 0; i < N_DEV; i++) begin
      if (irq_req[i] && (irq_pl[3*i +: 3] > psr_pl) &&
          (!any_elig || (irq_pl[3*i +: 3] > win_pl))) begin
        any_elig = 1'b1;
        win_idx  = 2'(i);
        win_pl   = irq_pl[3*i +: 3];
      end
    end
  end

endmodule

// File: rtl/lc3_int_ctrl.sv
// lc3_int_ctrl -- LC3 interrupt/exception controller.
// Latches exception pulses, arbitrates them against device interrupts, and
// walks the vector unit through LOAD -> READY -> ACK once the control FSM
// takes the event at an instruction boundary.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   irq_req/irq_pl/irq_vec        per-device request, priority, INTV
//   psr_pl                        current processor priority
//   exc_priv/exc_illop/exc_acv    one-cycle exception pulses
//   int_take, vec_gate            handshake from the control FSM
//   int_pending, vec_ready        status to the control FSM
//   LDVector/TableMUX/GateVector/VectorMUX/INTV  vector-unit controls
//   int_ack                       one-hot acknowledge to serviced device
//   new_pl, is_exc                PSR priority to load / exception flag
//   dbg_state                     current FSM state (debug)
// Handshake: int_take is honoured only in IDLE while int_pending=1 (that edge
// captures the event); vec_gate is honoured only in READY while vec_ready=1,
// and the FSM moves to ACK on the same edge.
module lc3_int_ctrl
  import lc3_int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  irq_req,
  input  logic [11:0] irq_pl,
  input  logic [31:0] irq_vec,
  input  logic [2:0]  psr_pl,
  input  logic        exc_priv,
  input  logic        exc_illop,
  input  logic        exc_acv,
  input  logic        int_take,
  input  logic        vec_gate,
  output logic        int_pending,
  output logic        vec_ready,
  output logic        LDVector,
  output logic        TableMUX,
  output logic        GateVector,
  output logic [1:0]  VectorMUX,
  output logic [7:0]  INTV,
  output logic [3:0]  int_ack,
  output logic [2:0]  new_pl,
  output logic        is_exc,
  output logic [1:0]  dbg_state
);

  state_e      state_q, state_d;
  logic        priv_q, illop_q, acv_q;
  logic        priv_d, illop_d, acv_d;
  logic [1:0]  cap_mux_q, cap_idx_q;
  logic [7:0]  cap_vec_q;
  logic [2:0]  cap_pl_q;

  logic        any_elig;
  logic [1:0]  win_idx;
  logic [2:0]  win_pl;
  logic [1:0]  win_mux;
  logic        take_fire;

  lc3_int_prio u_prio (
    .irq_req  (irq_req),
    .irq_pl   (irq_pl),
    .psr_pl   (psr_pl),
    .any_elig (any_elig),
    .win_idx  (win_idx),
    .win_pl   (win_pl)
  );

  // Exceptions always outrank interrupts: priv > illop > acv > device.
  always_comb begin
    if (priv_q)       win_mux = VM_PRIV;
    else if (illop_q) win_mux = VM_ILLOP;
    else if (acv_q)   win_mux = VM_ACV;
    else              win_mux = VM_INT;
  end

  assign int_pending = (state_q == ST_IDLE) &&
                       (priv_q || illop_q || acv_q || any_elig);
  assign take_fire   = int_pending && int_take;

  // Sticky latches: a new pulse wins over the ACK-cycle clear.
  always_comb begin
    priv_d  = exc_priv  | (priv_q  & ~((state_q == ST_ACK) && (cap_mux_q == VM_PRIV)));
    illop_d = exc_illop | (illop_q & ~((state_q == ST_ACK) && (cap_mux_q == VM_ILLOP)));
    acv_d   = exc_acv   | (acv_q   & ~((state_q == ST_ACK) && (cap_mux_q == VM_ACV)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      priv_q  <= 1'b0;
      illop_q <= 1'b0;
      acv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      priv_q  <= priv_d;
      illop_q <= illop_d;
      acv_q   <= acv_d;
    end
  end

  // Capture the winner on the take edge; later changes of requests or
  // psr_pl therefore cannot disturb the in-flight event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_mux_q <= VM_INT;
      cap_idx_q <= 2'd0;
      cap_vec_q <= 8'h00;
      cap_pl_q  <= 3'd0;
    end else if (take_fire) begin
      cap_mux_q <= win_mux;
      cap_idx_q <= win_idx;
      cap_vec_q <= (win_mux == VM_INT) ? irq_vec[8*win_idx +: 8] : 8'h00;
      cap_pl_q  <= (win_mux == VM_INT) ? win_pl : psr_pl;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_ready  = 1'b0;
    LDVector   = 1'b0;
    TableMUX   = 1'b0;
    GateVector = 1'b0;
    VectorMUX  = VM_INT;
    INTV       = 8'h00;
    int_ack    = 4'b0000;
    new_pl     = 3'd0;
    is_exc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take_fire) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        LDVector  = 1'b1;
        TableMUX  = 1'b1;
        VectorMUX = cap_mux_q;
        INTV      = cap_vec_q;
        new_pl    = cap_pl_q;
        is_exc    = (cap_mux_q != VM_INT);
        state_d   = ST_READY;
      end
      ST_READY: begin
        vec_ready  = 1'b1;
        GateVector = vec_gate;
        new_pl     = cap_pl_q;
        is_exc     = (cap_mux_q != VM_INT);
        if (vec_gate) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (cap_mux_q == VM_INT) int_ack = 4'b0001 << cap_idx_q;
        new_pl  = cap_pl_q;
        is_exc  = (cap_mux_q != VM_INT);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// tb_lc3_int_ctrl -- directed self-checking bench for lc3_int_ctrl.
module tb_lc3_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq_req;
  logic [11:0] irq_pl;
  logic [31:0] irq_vec;
  logic [2:0]  psr_pl;
  logic        exc_priv, exc_illop, exc_acv;
  logic        int_take, vec_gate;
  logic        int_pending, vec_ready, LDVector, TableMUX, GateVector;
  logic [1:0]  VectorMUX;
  logic [7:0]  INTV;
  logic [3:0]  int_ack;
  logic [2:0]  new_pl;
  logic        is_exc;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_READY = 2'd2, S_ACK = 2'd3;

  lc3_int_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_req     (irq_req),
    .irq_pl      (irq_pl),
    .irq_vec     (irq_vec),
    .psr_pl      (psr_pl),
    .exc_priv    (exc_priv),
    .exc_illop   (exc_illop),
    .exc_acv     (exc_acv),
    .int_take    (int_take),
    .vec_gate    (vec_gate),
    .int_pending (int_pending),
    .vec_ready   (vec_ready),
    .LDVector    (LDVector),
    .TableMUX    (TableMUX),
    .GateVector  (GateVector),
    .VectorMUX   (VectorMUX),
    .INTV        (INTV),
    .int_ack     (int_ack),
    .new_pl      (new_pl),
    .is_exc      (is_exc),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All vector-unit / status outputs quiet and FSM in IDLE.
  task automatic chk_quiet(input string tag);
    chk({tag, ".state"}, 32'(dbg_state), 32'(S_IDLE));
    chk({tag, ".outs"},
        {vec_ready, LDVector, TableMUX, GateVector, VectorMUX, INTV, int_ack, new_pl, is_exc},
        '0);
  endtask

  // Full take -> LOAD -> READY -> ACK -> IDLE with immediate gate.
  task automatic service(input string tag, input logic [1:0] e_mux, input logic [7:0] e_intv,
                         input logic [2:0] e_pl, input logic e_exc, input logic [3:0] e_ack);
    chk({tag, ".pending"}, 32'(int_pending), 32'd1);
    int_take = 1'b1;
    step();
    int_take = 1'b0;
    chk({tag, ".load_state"}, 32'(dbg_state), 32'(S_LOAD));
    chk({tag, ".load_ctl"}, {LDVector, TableMUX, vec_ready, int_ack}, {3'b110, 4'b0000});
    chk({tag, ".vmux"}, 32'(VectorMUX), 32'(e_mux));
    chk({tag, ".intv"}, 32'(INTV), 32'(e_intv));
    chk({tag, ".new_pl"}, 32'(new_pl), 32'(e_pl));
    chk({tag, ".is_exc"}, 32'(is_exc), 32'(e_exc));
    step();
    chk({tag, ".ready"}, {vec_ready, LDVector, GateVector, int_pending}, 4'b1000);
    vec_gate = 1'b1;
    #1;
    chk({tag, ".gate"}, 32'(GateVector), 32'd1);
    step();
    vec_gate = 1'b0;
    chk({tag, ".ack_state"}, 32'(dbg_state), 32'(S_ACK));
    chk({tag, ".ack"}, 32'(int_ack), 32'(e_ack));
    chk({tag, ".ack_pl"}, {new_pl, is_exc}, {e_pl, e_exc});
    step();
    chk({tag, ".back_idle"}, {dbg_state, int_ack, new_pl}, '0);
  endtask

  initial begin
    rst_n = 1'b0; irq_req = '0; irq_pl = '0; irq_vec = '0; psr_pl = '0;
    exc_priv = 0; exc_illop = 0; exc_acv = 0; int_take = 0; vec_gate = 0;
    #2;
    step(); step();
    chk_quiet("reset");
    chk("reset.pending", 32'(int_pending), 32'd0);
    rst_n = 1'b1;
    step();

    // Two devices tie at pl 4 over psr 2 -> device 0 wins.
    psr_pl = 3'd2; irq_req = 4'b0101;
    irq_pl = {3'd0, 3'd4, 3'd0, 3'd4};
    irq_vec = {8'h00, 8'h90, 8'h00, 8'h80};
    #1;
    service("tie", 2'b00, 8'h80, 3'd4, 1'b0, 4'b0001);
    chk("tie.still_pending", 32'(int_pending), 32'd1);

    // Highest pl wins; tie on pl 5 between dev1 and dev3 -> dev1.
    irq_req = 4'b1111; irq_pl = {3'd5, 3'd3, 3'd5, 3'd1};
    irq_vec = {8'hF3, 8'h33, 8'h11, 8'h01};
    #1;
    service("hipl", 2'b00, 8'h11, 3'd5, 1'b0, 4'b0010);

    // Only device 3, pl 7 over psr 6.
    irq_req = 4'b1000; psr_pl = 3'd6; irq_pl = {3'd7, 3'd6, 3'd6, 3'd6};
    #1;
    service("dev3", 2'b00, 8'hF3, 3'd7, 1'b0, 4'b1000);

    // pl equal to psr is not eligible; take ignored.
    irq_req = 4'b0001; irq_pl = {9'd0, 3'd3}; psr_pl = 3'd3;
    #1;
    chk("noelig.pending", 32'(int_pending), 32'd0);
    int_take = 1'b1;
    step();
    int_take = 1'b0;
    chk_quiet("noelig");

    // Same-cycle priv + acv with an eligible device pending.
    irq_req = 4'b0001; irq_pl = {9'd0, 3'd5}; psr_pl = 3'd2;
    irq_vec = {24'h0, 8'h40};
    exc_priv = 1'b1; exc_acv = 1'b1;
    step();
    exc_priv = 1'b0; exc_acv = 1'b0;
    service("exc1", 2'b01, 8'h00, 3'd2, 1'b1, 4'b0000);
    service("exc2", 2'b11, 8'h00, 3'd2, 1'b1, 4'b0000);
    service("exc3", 2'b00, 8'h40, 3'd5, 1'b0, 4'b0001);

    // Stall in READY for 5 cycles; an illop arriving meanwhile is kept.
    int_take = 1'b1;
    step();
    int_take = 1'b0;
    step();
    exc_illop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall.ready", {dbg_state, vec_ready, GateVector}, {S_READY, 2'b10});
      step();
      exc_illop = 1'b0;
    end
    vec_gate = 1'b1;
    #1;
    chk("stall.gate", 32'(GateVector), 32'd1);
    step();
    vec_gate = 1'b0;
    chk("stall.ack", {dbg_state, int_ack}, {S_ACK, 4'b0001});
    irq_req = 4'b0000;
    step();
    chk("illop.latched", 32'(int_pending), 32'd1);
    service("illop", 2'b10, 8'h00, 3'd2, 1'b1, 4'b0000);
    chk("illop.cleared", 32'(int_pending), 32'd0);

    // Reset in READY discards the event and a freshly latched illop.
    irq_req = 4'b0001;
    #1;
    int_take = 1'b1;
    step();
    int_take = 1'b0;
    exc_illop = 1'b1;
    step();
    exc_illop = 1'b0;
    chk("rst.in_ready", 32'(dbg_state), 32'(S_READY));
    rst_n = 1'b0;
    step();
    chk_quiet("rst.mid");
    irq_req = 4'b0000;
    rst_n = 1'b1;
    step();
    chk_quiet("rst.after");
    chk("rst.illop_gone", 32'(int_pending), 32'd0);

    // Request drop and psr change during LOAD do not disturb the event.
    irq_req = 4'b0100; psr_pl = 3'd0;
    irq_pl = {3'd0, 3'd7, 6'd0}; irq_vec = {8'h00, 8'hA5, 16'h0};
    #1;
    int_take = 1'b1;
    step();
    int_take = 1'b0;
    irq_req = 4'b0000; psr_pl = 3'd7;
    #1;
    chk("drop.load", {dbg_state, INTV, new_pl}, {S_LOAD, 8'hA5, 3'd7});
    step();
    vec_gate = 1'b1;
    step();
    vec_gate = 1'b0;
    chk("drop.ack", {dbg_state, int_ack, new_pl}, {S_ACK, 4'b0100, 3'd7});
    step();
    chk_quiet("drop.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
